md_unit: RTL

//  Multi-cycle multiply/divide unit and owner of the HI/LO registers.
//  The EX-stage writeback mux reads HI/LO; this block is their only writer.
//  It sits in EX beside the ALU and takes RS/RT after forwarding.

---
 rtl/md_defs.sv | 18 +
 rtl/md_arith.sv | 62 ++++++
 rtl/md_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit: op codes and FSM state encoding.
package md_defs;

  localparam int unsigned MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi, lo} result.
module md_arith
  import md_defs::*;
(
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [31:0]        a_i,
  input  logic [31:0]        b_i,
  output logic [31:0]        hi_o,
  output logic [31:0]        lo_o
);

  logic               is_signed;
  logic               ext_a, ext_b;
  logic signed [63:0] prod;
  logic               neg_a, neg_b, b_zero;
  logic [31:0]        mag_a, mag_b, divisor;
  logic [31:0]        quo_u, rem_u, quo, rem;

  // One shared multiplier and one unsigned divider; sign handling wraps around them.
  // The div overflow case (-2^31 / -1) falls out of the magnitude path: 2^31 / 1 with
  // matching signs yields quotient 32'h8000_0000 and remainder 0.
  always_comb begin
    is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    ext_a     = is_signed & a_i[31];
    ext_b     = is_signed & b_i[31];
    prod      = $signed({ext_a, a_i}) * $signed({ext_b, b_i});

    neg_a   = (op_i == MD_DIV) && a_i[31];
    neg_b   = (op_i == MD_DIV) && b_i[31];
    b_zero  = (b_i == 32'd0);
    mag_a   = neg_a ? (~a_i + 32'd1) : a_i;
    mag_b   = neg_b ? (~b_i + 32'd1) : b_i;
    divisor = b_zero ? 32'd1 : mag_b;
    quo_u   = mag_a / divisor;
    rem_u   = mag_a % divisor;
    quo     = (neg_a ^ neg_b) ? (~quo_u + 32'd1) : quo_u;
    rem     = neg_a ? (~rem_u + 32'd1) : rem_u;

    hi_o = 32'd0;
    lo_o = 32'd0;
    case (op_i)
      MD_MULT, MD_MULTU: begin
        hi_o = prod[63:32];
        lo_o = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        if (b_zero) begin
          hi_o = a_i;
          lo_o = 32'hFFFF_FFFF;
        end else begin
          hi_o = rem;
          lo_o = quo;
        end
      end
      default: begin
        hi_o = 32'd0;
        lo_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit; sole writer of the HI/LO registers.
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] MD_op,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  output logic               Busy,
  output logic [31:0]        HI,
  output logic [31:0]        LO
);

  localparam int unsigned MaxN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW = (MaxN > 1) ? $clog2(MaxN) : 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] arith_hi, arith_lo;
  logic        idle_start, launch, done;

  md_arith u_arith (
    .op_i (MD_op),
    .a_i  (A),
    .b_i  (B),
    .hi_o (arith_hi),
    .lo_o (arith_lo)
  );

  // Starts are only honoured in IDLE; anything arriving while busy is dropped.
  assign idle_start = start && (state_q == StIdle);
  assign launch     = idle_start && (MD_op <= MD_DIVU);
  assign done       = (state_q == StRun) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (launch) state_d = StRun;
      StRun:  if (done)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy = (state_q == StRun);
  end

  // Down-counter, pending result and HI/LO next-state
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (launch) begin
      // MD_op[1] separates div/divu from mult/multu.
      cnt_d     = MD_op[1] ? DivLoad : MultLoad;
      pend_hi_d = arith_hi;
      pend_lo_d = arith_lo;
    end else if (state_q == StRun && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (done) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end else if (idle_start && MD_op == MD_MTHI) begin
      hi_d = A;
    end else if (idle_start && MD_op == MD_MTLO) begin
      lo_d = A;
    end
  end

  // Counter, pending and architectural HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule
